ram_responder_bram: RTL and testbench

Synthesizable block-RAM responder for the user side of the DDR2 wrapper protocol: address, data_in, write_enable, read_request, read_ack, data_out, rdy, rd_data_pres and max_ram_address.
- Drop-in stand-in for ram_interface_wrapper, so mem_interface and the picoBlaze audio path run in simulation and on builds without DDR2.
- Emulates wrapper timing: init delay, write busy time, read latency, and read data held until acknowledged.

---
 rtl/ram_resp_pkg.sv | 17 +
 rtl/ram_resp_spram.sv | 24 ++
 rtl/ram_responder_bram.sv | 128 ++++++++++++
 tb/tb_ram_responder_bram.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_resp_pkg.sv
// Shared types for the block-RAM stand-in of the DDR2 wrapper.
// FSM state encoding, default bus widths, counter width.
package ram_resp_pkg;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WBUSY = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

endpackage

// File: rtl/ram_resp_spram.sv
// Single-port synchronous RAM, DATA_W x 2^DEPTH_LOG2, registered read.
// Ports: clk, we, addr, wdata in; rdata out (not updated on write cycles).
module ram_resp_spram #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // No read on a write cycle, so no read-during-write behaviour to define.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else
      rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder_bram.sv
// Block-RAM responder mimicking ram_interface_wrapper user-side timing.
// Ports: CLK, reset, address, data_in, write_enable, read_request,
//   read_ack in; data_out, rdy, rd_data_pres, max_ram_address out.
module ram_responder_bram
  import ram_resp_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH_LOG2   = 12,
  parameter int INIT_CYCLES  = 16,
  parameter int WRITE_BUSY   = 2,
  parameter int READ_LATENCY = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  input  logic              read_request,
  input  logic              read_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              rdy,
  output logic              rd_data_pres,
  output logic [ADDR_W-1:0] max_ram_address
);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_q;
  logic                    ram_we;
  logic                    ld_addr;
  logic                    capture;
  logic                    drop;
  logic                    unused_hi;

  assign unused_hi = ^address[ADDR_W-1:DEPTH_LOG2];

  assign max_ram_address = {{(ADDR_W-DEPTH_LOG2){1'b0}},
                            {DEPTH_LOG2{1'b1}}};

  assign rdy = (state == ST_IDLE) || (state == ST_RDATA);

  // Commands use the live address; the read wait uses the latched one.
  assign ram_addr = (state == ST_IDLE) ?
                    address[DEPTH_LOG2-1:0] : addr_q;

  ram_resp_spram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_in),
    .rdata (ram_q)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ram_we   = 1'b0;
    ld_addr  = 1'b0;
    capture  = 1'b0;
    drop     = 1'b0;
    unique case (state)
      ST_INIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == '0)
          state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (write_enable) begin
          ram_we   = 1'b1;
          cnt_nx   = CNT_W'(WRITE_BUSY - 1);
          state_nx = ST_WBUSY;
        end else if (read_request) begin
          ld_addr  = 1'b1;
          // One of the READ_LATENCY edges is the RAM output register.
          cnt_nx   = CNT_W'(READ_LATENCY - 1);
          state_nx = ST_RWAIT;
        end
      end
      ST_WBUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == '0)
          state_nx = ST_IDLE;
      end
      ST_RWAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (read_ack) begin
          drop     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state        <= ST_INIT;
      cnt          <= CNT_W'(INIT_CYCLES - 1);
      addr_q       <= '0;
      data_out     <= '0;
      rd_data_pres <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ld_addr)
        addr_q <= address[DEPTH_LOG2-1:0];
      if (capture) begin
        data_out     <= ram_q;
        rd_data_pres <= 1'b1;
      end else if (drop) begin
        rd_data_pres <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_responder_bram.sv
// Scoreboard bench for ram_responder_bram: directed writes/reads,
// aliasing, simultaneous commands, mid-read reset, level writes.
module tb_ram_responder_bram;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] address = '0;
  logic [15:0] data_in = '0;
  logic        write_enable = 1'b0;
  logic        read_request = 1'b0;
  logic        read_ack = 1'b0;
  logic [15:0] data_out;
  logic        rdy;
  logic        rd_data_pres;
  logic [25:0] max_ram_address;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        prev_pres = 1'b0;
  logic [15:0] held = '0;

  always #5 CLK = ~CLK;

  ram_responder_bram dut (
    .CLK             (CLK),
    .reset           (reset),
    .address         (address),
    .data_in         (data_in),
    .write_enable    (write_enable),
    .read_request    (read_request),
    .read_ack        (read_ack),
    .data_out        (data_out),
    .rdy             (rdy),
    .rd_data_pres    (rd_data_pres),
    .max_ram_address (max_ram_address)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected word on each rd_data_pres rise and
  // checks data_out stays put while rd_data_pres is held.
  always @(negedge CLK) begin
    if (rd_data_pres && !prev_pres) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rd_data_pres", 32'(rd_data_pres), 32'd0);
      end else begin
        chk("read_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      held = data_out;
    end else if (rd_data_pres && prev_pres) begin
      chk("data_hold", 32'(data_out), 32'(held));
    end
    prev_pres = rd_data_pres;
  end

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!rdy) chk("rdy_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic init_wait();
    int n = 0;
    while (!rdy && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("init_cycles", 32'(n), 32'd16);
  endtask

  task automatic do_write(input logic [25:0] a, input logic [15:0] d);
    wait_rdy();
    @(negedge CLK);
    address = a;
    data_in = d;
    write_enable = 1'b1;
    @(posedge CLK);
    #1;
    write_enable = 1'b0;
    chk("wbusy_rdy_c1", 32'(rdy), 32'd0);
    @(posedge CLK);
    #1;
    chk("wbusy_rdy_c2", 32'(rdy), 32'd0);
    @(posedge CLK);
    #1;
    chk("wbusy_rdy_end", 32'(rdy), 32'd1);
  endtask

  task automatic do_read(input logic [25:0] a, input logic [15:0] e);
    int n = 0;
    wait_rdy();
    @(negedge CLK);
    address = a;
    read_request = 1'b1;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    read_request = 1'b0;
    while (!rd_data_pres && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("read_latency", 32'(n), 32'd4);
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("pres_held", 32'(rd_data_pres), 32'd1);
    end
    @(negedge CLK);
    read_ack = 1'b1;
    @(posedge CLK);
    #1;
    read_ack = 1'b0;
    chk("pres_after_ack", 32'(rd_data_pres), 32'd0);
    chk("rdy_after_ack", 32'(rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_pres", 32'(rd_data_pres), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);
    chk("max_addr", 32'(max_ram_address), 32'h0000FFF);
    @(negedge CLK);
    reset = 1'b0;
    init_wait();

    do_write(26'h005, 16'hBEEF);
    do_read(26'h005, 16'hBEEF);

    do_write(26'h0001003, 16'h1234);
    do_read(26'h0000003, 16'h1234);

    // Write wins; read is dropped.
    wait_rdy();
    @(negedge CLK);
    address = 26'h010;
    data_in = 16'hA5A5;
    write_enable = 1'b1;
    read_request = 1'b1;
    @(posedge CLK);
    #1;
    write_enable = 1'b0;
    read_request = 1'b0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      chk("dropped_read", 32'(rd_data_pres), 32'd0);
    end
    do_read(26'h010, 16'hA5A5);

    // Reset two cycles into the read wait.
    wait_rdy();
    @(negedge CLK);
    address = 26'h005;
    read_request = 1'b1;
    @(posedge CLK);
    #1;
    read_request = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_rdy", 32'(rdy), 32'd0);
    chk("midreset_pres", 32'(rd_data_pres), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    init_wait();
    do_read(26'h005, 16'hBEEF);

    // Level write held across several loops: repeats are harmless.
    wait_rdy();
    @(negedge CLK);
    address = 26'h022;
    data_in = 16'h00C3;
    write_enable = 1'b1;
    repeat (7) @(posedge CLK);
    #1;
    write_enable = 1'b0;
    do_read(26'h022, 16'h00C3);
    do_read(26'h0001005, 16'hBEEF);

    repeat (3) @(posedge CLK);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
